// File: rtl/ram_io_responder_pkg.sv
// Shared memory-map constants and IO register decode for the RAM/IO responder and mem_ctrl.
package ram_io_responder_pkg;

  localparam logic [1:0]  IO_SPACE_SEL        = 2'b11;
  localparam logic [31:0] IO_TX_ADDR          = 32'h0003_0000;
  localparam logic [31:0] IO_CTRL_ADDR        = 32'h0003_0004;
  localparam int          TX_DEPTH_DEFAULT    = 8;
  localparam int          FULL_MARGIN_DEFAULT = 2;

  typedef enum logic [1:0] {
    IO_REG_TX   = 2'd0,
    IO_REG_CTRL = 2'd1,
    IO_REG_NONE = 2'd2
  } io_reg_e;

  // Only the low half-word selects a register once the IO space is chosen.
  function automatic io_reg_e io_decode(input logic [15:0] offset);
    io_reg_e reg_sel;
    case (offset)
      IO_TX_ADDR[15:0]:   reg_sel = IO_REG_TX;
      IO_CTRL_ADDR[15:0]: reg_sel = IO_REG_CTRL;
      default:            reg_sel = IO_REG_NONE;
    endcase
    return reg_sel;
  endfunction

endpackage

// File: rtl/ram_io_responder_byte_fifo.sv
// Byte-wide TX FIFO; a push is accepted while full only if a pop frees the head slot in the same cycle.
module byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   count_nxt,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [0:DEPTH-1];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == {CW{1'b0}});
  assign pop_ok_s  = pop & ~empty;
  assign push_ok_s = push & (~full | pop_ok_s);
  assign dout      = mem[rd_ptr_q];
  assign count     = count_q;
  assign count_nxt = count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    count_d = count_q + CW'(push_ok_s) - CW'(pop_ok_s);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/ram_io_responder.sv
// Byte RAM plus memory-mapped IO (TX FIFO, RX holding register, program-end strobe) behind one access port.
module ram_io_responder
  import ram_io_responder_pkg::*;
#(
  parameter int RAM_AW      = 17,
  parameter int TX_DEPTH    = TX_DEPTH_DEFAULT,
  parameter int FULL_MARGIN = FULL_MARGIN_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic        ram_read_or_write,
  input  logic [31:0] addr_to_ram,
  input  logic [7:0]  data_write_out,
  output logic [7:0]  data_read_in,
  output logic        io_buffer_full,
  output logic [7:0]  io_tx_data,
  output logic        io_tx_valid,
  input  logic        io_tx_ready,
  input  logic [7:0]  io_rx_data,
  input  logic        io_rx_valid,
  output logic        io_rx_ready,
  output logic        tx_overflow,
  output logic        program_end
);

  localparam int            CW      = $clog2(TX_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_TH = CW'(TX_DEPTH - FULL_MARGIN);

  logic [7:0]        mem [0:(2**RAM_AW)-1];
  logic [RAM_AW-1:0] ram_idx_s;
  logic              io_sel_s;
  io_reg_e           io_reg_s;
  logic              wr_acc_s;
  logic              rd_acc_s;
  logic              unused_addr_s;

  logic              tx_push_s;
  logic              tx_pop_s;
  logic              tx_full_s;
  logic              tx_empty_s;
  logic [CW-1:0]     tx_count_nxt_s;
  logic [CW-1:0]     unused_tx_count_s;
  logic              rx_pop_s;

  logic [7:0] data_read_q, data_read_d;
  logic       io_buffer_full_q, io_buffer_full_d;
  logic       tx_overflow_q, tx_overflow_d;
  logic       program_end_q, program_end_d;
  logic       rx_full_q, rx_full_d;
  logic [7:0] rx_data_q, rx_data_d;

  assign ram_idx_s     = addr_to_ram[RAM_AW-1:0];
  assign io_sel_s      = (addr_to_ram[17:16] == IO_SPACE_SEL);
  assign io_reg_s      = io_decode(addr_to_ram[15:0]);
  assign wr_acc_s      = rdy & ram_read_or_write;
  assign rd_acc_s      = rdy & ~ram_read_or_write;
  assign unused_addr_s = ^addr_to_ram[31:18];

  assign tx_pop_s    = io_tx_valid & io_tx_ready;
  assign io_tx_valid = ~tx_empty_s;

  byte_fifo #(
    .DEPTH(TX_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (tx_push_s),
    .din       (data_write_out),
    .pop       (tx_pop_s),
    .dout      (io_tx_data),
    .count     (unused_tx_count_s),
    .count_nxt (tx_count_nxt_s),
    .full      (tx_full_s),
    .empty     (tx_empty_s)
  );

  always_ff @(posedge clk) begin
    if (wr_acc_s && !io_sel_s) begin
      mem[ram_idx_s] <= data_write_out;
    end
  end

  // Write side effects and read-data selection; the RAM read sees the pre-edge contents.
  always_comb begin
    data_read_d   = data_read_q;
    tx_push_s     = 1'b0;
    program_end_d = 1'b0;
    rx_pop_s      = 1'b0;
    if (wr_acc_s && io_sel_s) begin
      case (io_reg_s)
        IO_REG_TX:   tx_push_s     = 1'b1;
        IO_REG_CTRL: program_end_d = 1'b1;
        default:     tx_push_s     = 1'b0;
      endcase
    end else begin
      tx_push_s = 1'b0;
    end
    if (rd_acc_s) begin
      if (io_sel_s) begin
        case (io_reg_s)
          IO_REG_TX: begin
            if (rx_full_q) begin
              data_read_d = rx_data_q;
              rx_pop_s    = 1'b1;
            end else begin
              data_read_d = 8'h00;
            end
          end
          IO_REG_CTRL: data_read_d = {6'b000000, ~io_buffer_full_q, rx_full_q};
          default:     data_read_d = 8'h00;
        endcase
      end else begin
        data_read_d = mem[ram_idx_s];
      end
    end else begin
      data_read_d = data_read_q;
    end
  end

  // A pop blocks the load in the same cycle because loading needs the register to start empty.
  always_comb begin
    rx_full_d = rx_full_q;
    rx_data_d = rx_data_q;
    if (rx_pop_s) begin
      rx_full_d = 1'b0;
    end else if (!rx_full_q && io_rx_valid) begin
      rx_full_d = 1'b1;
      rx_data_d = io_rx_data;
    end else begin
      rx_full_d = rx_full_q;
    end
    io_buffer_full_d = (tx_count_nxt_s >= FULL_TH);
    tx_overflow_d    = tx_overflow_q | (tx_push_s & tx_full_s & ~tx_pop_s);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_read_q      <= 8'h00;
      io_buffer_full_q <= 1'b0;
      tx_overflow_q    <= 1'b0;
      program_end_q    <= 1'b0;
      rx_full_q        <= 1'b0;
      rx_data_q        <= 8'h00;
    end else begin
      data_read_q      <= data_read_d;
      io_buffer_full_q <= io_buffer_full_d;
      tx_overflow_q    <= tx_overflow_d;
      program_end_q    <= program_end_d;
      rx_full_q        <= rx_full_d;
      rx_data_q        <= rx_data_d;
    end
  end

  assign data_read_in   = data_read_q;
  assign io_buffer_full = io_buffer_full_q;
  assign tx_overflow    = tx_overflow_q;
  assign program_end    = program_end_q;
  assign io_rx_ready    = ~rx_full_q;

endmodule

// File: tb/tb_ram_io_responder.sv
// Directed bench for ram_io_responder: queue/array reference model checked every cycle, plus literal spot checks.
module tb_ram_io_responder;

  logic        clk;
  logic        rst_n;
  logic        rdy;
  logic        ram_read_or_write;
  logic [31:0] addr_to_ram;
  logic [7:0]  data_write_out;
  logic [7:0]  data_read_in;
  logic        io_buffer_full;
  logic [7:0]  io_tx_data;
  logic        io_tx_valid;
  logic        io_tx_ready;
  logic [7:0]  io_rx_data;
  logic        io_rx_valid;
  logic        io_rx_ready;
  logic        tx_overflow;
  logic        program_end;

  int checks = 0;
  int errors = 0;

  ram_io_responder dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .rdy               (rdy),
    .ram_read_or_write (ram_read_or_write),
    .addr_to_ram       (addr_to_ram),
    .data_write_out    (data_write_out),
    .data_read_in      (data_read_in),
    .io_buffer_full    (io_buffer_full),
    .io_tx_data        (io_tx_data),
    .io_tx_valid       (io_tx_valid),
    .io_tx_ready       (io_tx_ready),
    .io_rx_data        (io_rx_data),
    .io_rx_valid       (io_rx_valid),
    .io_rx_ready       (io_rx_ready),
    .tx_overflow       (tx_overflow),
    .program_end       (program_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: RAM as a sparse map, TX FIFO as a queue.
  logic [7:0] mram [logic [16:0]];
  logic [7:0] tx_q [$];
  logic [7:0] m_rd       = 8'h00;
  bit         m_rd_known = 1'b1;
  bit         m_full     = 1'b0;
  bit         m_ovf      = 1'b0;
  bit         m_pend     = 1'b0;
  bit         m_rx_full  = 1'b0;
  logic [7:0] m_rx_byte  = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    tx_q.delete();
    m_rd       = 8'h00;
    m_rd_known = 1'b1;
    m_full     = 1'b0;
    m_ovf      = 1'b0;
    m_pend     = 1'b0;
    m_rx_full  = 1'b0;
    m_rx_byte  = 8'h00;
  endtask

  task automatic model_step();
    bit          popped;
    bit          push_req;
    bit          was_rx;
    bit          is_io;
    logic [15:0] off;
    logic [16:0] idx;
    popped   = (tx_q.size() > 0) && io_tx_ready;
    push_req = 1'b0;
    was_rx   = m_rx_full;
    is_io    = (addr_to_ram[17:16] == 2'b11);
    off      = addr_to_ram[15:0];
    idx      = addr_to_ram[16:0];
    m_pend   = 1'b0;
    if (rdy) begin
      if (ram_read_or_write) begin
        if (is_io) begin
          if (off == 16'h0000) begin
            if (tx_q.size() == 8 && !popped) m_ovf = 1'b1;
            else push_req = 1'b1;
          end else if (off == 16'h0004) begin
            m_pend = 1'b1;
          end
        end else begin
          mram[idx] = data_write_out;
        end
      end else begin
        m_rd_known = 1'b1;
        if (is_io) begin
          if (off == 16'h0000) begin
            if (was_rx) begin
              m_rd      = m_rx_byte;
              m_rx_full = 1'b0;
            end else begin
              m_rd = 8'h00;
            end
          end else if (off == 16'h0004) begin
            m_rd = {6'b000000, !m_full, was_rx};
          end else begin
            m_rd = 8'h00;
          end
        end else if (mram.exists(idx)) begin
          m_rd = mram[idx];
        end else begin
          m_rd_known = 1'b0;
        end
      end
    end
    if (popped) void'(tx_q.pop_front());
    if (push_req) tx_q.push_back(data_write_out);
    if (!was_rx && io_rx_valid) begin
      m_rx_full = 1'b1;
      m_rx_byte = io_rx_data;
    end
    m_full = (tx_q.size() >= 6);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  // Per-cycle comparison against the model, on the falling edge.
  always @(negedge clk) begin
    if (m_rd_known) chk("rd_data", data_read_in, m_rd);
    chk("buf_full", io_buffer_full, m_full);
    chk("tx_valid", io_tx_valid, tx_q.size() > 0);
    if (tx_q.size() > 0) chk("tx_head", io_tx_data, tx_q[0]);
    chk("rx_ready", io_rx_ready, !m_rx_full);
    chk("tx_ovf", tx_overflow, m_ovf);
    chk("prog_end", program_end, m_pend);
  end

  task automatic step(input logic r, input logic w, input logic [31:0] a, input logic [7:0] d);
    rdy               = r;
    ram_read_or_write = w;
    addr_to_ram       = a;
    data_write_out    = d;
    @(posedge clk);
    #2;
  endtask

  logic [7:0] drain_exp [8] = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h19};

  initial begin
    rst_n             = 1'b0;
    rdy               = 1'b0;
    ram_read_or_write = 1'b0;
    addr_to_ram       = 32'h0;
    data_write_out    = 8'h00;
    io_tx_ready       = 1'b0;
    io_rx_data        = 8'h00;
    io_rx_valid       = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    chk("rst_rd", data_read_in, 32'h0);
    chk("rst_rx_ready", io_rx_ready, 32'h1);
    chk("rst_tx_valid", io_tx_valid, 32'h0);

    // RAM write/read, hold, decode aliasing and top-of-RAM boundary
    step(1'b1, 1'b1, 32'h0000_0100, 8'hA5);
    step(1'b1, 1'b0, 32'h0000_0100, 8'h00);
    chk("ram_rd_a5", data_read_in, 32'hA5);
    step(1'b0, 1'b0, 32'h0, 8'h00);
    chk("ram_rd_hold", data_read_in, 32'hA5);
    step(1'b1, 1'b1, 32'h0001_FFFF, 8'h12);
    step(1'b1, 1'b1, 32'h0002_0100, 8'h5A);
    step(1'b1, 1'b0, 32'h0001_FFFF, 8'h00);
    chk("ram_rd_top", data_read_in, 32'h12);
    step(1'b1, 1'b0, 32'h0000_0100, 8'h00);
    chk("ram_rd_alias", data_read_in, 32'h5A);

    // rdy low blocks the write and holds read data
    step(1'b1, 1'b1, 32'h0000_0010, 8'h11);
    step(1'b1, 1'b0, 32'h0000_0010, 8'h00);
    chk("ram_rd_11", data_read_in, 32'h11);
    step(1'b0, 1'b1, 32'h0000_0010, 8'h77);
    chk("rdy0_hold", data_read_in, 32'h11);
    step(1'b1, 1'b0, 32'h0000_0010, 8'h00);
    chk("rdy0_no_wr", data_read_in, 32'h11);
    step(1'b0, 1'b1, 32'h0003_0000, 8'h99);
    chk("rdy0_no_push", io_tx_valid, 32'h0);

    // Fill the TX FIFO, near-full threshold, overflow, then push+pop at full
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 32'h0003_0000, 8'h10 + 8'(i));
    chk("full_after5", io_buffer_full, 32'h0);
    step(1'b1, 1'b1, 32'h0003_0000, 8'h15);
    chk("full_after6", io_buffer_full, 32'h1);
    step(1'b1, 1'b1, 32'h0003_0000, 8'h16);
    step(1'b1, 1'b1, 32'h0003_0000, 8'h17);
    chk("ovf_at8", tx_overflow, 32'h0);
    step(1'b1, 1'b1, 32'h0003_0000, 8'h18);
    chk("ovf_after9", tx_overflow, 32'h1);
    chk("head_10", io_tx_data, 32'h10);
    io_tx_ready = 1'b1;
    step(1'b1, 1'b1, 32'h0003_0000, 8'h19);
    chk("pushpop_head", io_tx_data, 32'h11);
    chk("pushpop_full", io_buffer_full, 32'h1);
    chk("pushpop_ovf", tx_overflow, 32'h1);
    for (int i = 0; i < 8; i++) begin
      chk("drain_order", io_tx_data, drain_exp[i]);
      step(1'b0, 1'b0, 32'h0, 8'h00);
    end
    chk("drained_valid", io_tx_valid, 32'h0);
    chk("drained_full", io_buffer_full, 32'h0);
    io_tx_ready = 1'b0;

    // program_end pulse and unused IO addresses
    step(1'b1, 1'b1, 32'h0003_0004, 8'hFF);
    chk("pend_hi", program_end, 32'h1);
    chk("pend_no_push", io_tx_valid, 32'h0);
    step(1'b0, 1'b0, 32'h0, 8'h00);
    chk("pend_lo", program_end, 32'h0);
    step(1'b1, 1'b1, 32'h0003_0008, 8'h55);
    chk("io_other_wr", io_tx_valid, 32'h0);
    step(1'b1, 1'b0, 32'h0003_0008, 8'h00);
    chk("io_other_rd", data_read_in, 32'h0);
    step(1'b1, 1'b0, 32'h0003_0004, 8'h00);
    chk("status_empty", data_read_in, 32'h02);

    // RX holding register, including pop-blocks-load
    io_rx_data  = 8'h41;
    io_rx_valid = 1'b1;
    step(1'b0, 1'b0, 32'h0, 8'h00);
    io_rx_valid = 1'b0;
    chk("rx_loaded", io_rx_ready, 32'h0);
    step(1'b1, 1'b0, 32'h0003_0004, 8'h00);
    chk("status_rx", data_read_in, 32'h03);
    step(1'b1, 1'b0, 32'h0003_0000, 8'h00);
    chk("rx_rd_41", data_read_in, 32'h41);
    step(1'b1, 1'b0, 32'h0003_0000, 8'h00);
    chk("rx_rd_empty", data_read_in, 32'h00);
    io_rx_data  = 8'h42;
    io_rx_valid = 1'b1;
    step(1'b0, 1'b0, 32'h0, 8'h00);
    io_rx_data = 8'h43;
    step(1'b1, 1'b0, 32'h0003_0000, 8'h00);
    chk("rx_rd_42", data_read_in, 32'h42);
    chk("rx_pop_first", io_rx_ready, 32'h1);
    step(1'b0, 1'b0, 32'h0, 8'h00);
    chk("rx_load_next", io_rx_ready, 32'h0);
    io_rx_valid = 1'b0;
    step(1'b1, 1'b0, 32'h0003_0000, 8'h00);
    chk("rx_rd_43", data_read_in, 32'h43);

    // Asynchronous reset mid-drain; RAM survives
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 32'h0003_0000, 8'h21 + 8'(i));
    io_tx_ready = 1'b1;
    step(1'b0, 1'b0, 32'h0, 8'h00);
    chk("pre_rst_head", io_tx_data, 32'h22);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_tx_valid", io_tx_valid, 32'h0);
    chk("async_ovf", tx_overflow, 32'h0);
    chk("async_rd", data_read_in, 32'h0);
    io_tx_ready = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    chk("post_rst_valid", io_tx_valid, 32'h0);
    step(1'b1, 1'b0, 32'h0000_0100, 8'h00);
    chk("ram_keep_100", data_read_in, 32'h5A);
    step(1'b1, 1'b0, 32'h0001_FFFF, 8'h00);
    chk("ram_keep_top", data_read_in, 32'h12);
    step(1'b0, 1'b0, 32'h0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_io_responder.md
RAM_IO_RESPONDER -- requirements
Module: ram_io_responder

Interface
REQ-001 Parameters SHALL be: RAM_AW, default 17, RAM byte-address width; TX_DEPTH, default 8, TX FIFO entries (power of 2); FULL_MARGIN, default 2, free entries still left when io_buffer_full rises.
REQ-002 Ports SHALL be:
- clk  in  1  single clock, all state on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rdy  in  1  global ready; accesses are ignored when it is low.
- ram_read_or_write  in  1  1 = write byte, 0 = read.
- addr_to_ram  in  32  byte address.
- data_write_out  in  8  write data.
- data_read_in  out  8  registered read data.
- io_buffer_full  out  1  TX FIFO near full.
- io_tx_data  out  8  TX FIFO head byte.
- io_tx_valid  out  1  TX FIFO non-empty.
- io_tx_ready  in  1  consumer accepts the head byte.
- io_rx_data  in  8  input byte.
- io_rx_valid  in  1  input byte offered.
- io_rx_ready  out  1  RX holding register empty.
- tx_overflow  out  1  sticky flag: a push arrived while the FIFO was full.
- program_end  out  1  one-cycle pulse.

Function
REQ-003 Decode SHALL be: addr_to_ram[17:16]==2'b11 selects IO space, all other addresses select RAM; RAM index is addr_to_ram[RAM_AW-1:0].
REQ-004 A RAM write SHALL occur on the edge where rdy=1, ram_read_or_write=1 and the address is in RAM space.
REQ-005 A RAM read SHALL have one-cycle latency: the address presented in cycle t appears on data_read_in after edge t, and is held until the next read.
REQ-006 A read in the same cycle as a write to the same address SHALL return the old byte; the write is visible to the following cycle.
REQ-007 When rdy=0, no RAM write, FIFO push, RX pop or program_end SHALL occur, and data_read_in SHALL hold its value; the TX drain (REQ-010) continues.
REQ-008 An IO write to 0x30000 SHALL push data_write_out into the TX FIFO.
REQ-009 An IO write to 0x30004 SHALL pulse program_end for exactly one cycle; the data byte is ignored.
REQ-010 A TX pop SHALL occur when io_tx_valid and io_tx_ready are both 1; io_tx_data SHALL be the head byte combinationally.
REQ-011 io_buffer_full SHALL equal (count >= TX_DEPTH-FULL_MARGIN), registered from the post-edge count. The margin covers the initiator's one-cycle sample-to-write pipeline.
REQ-012 A push when count==TX_DEPTH SHALL be dropped and SHALL set tx_overflow, which stays set until reset.
REQ-013 A simultaneous push and pop SHALL leave count unchanged, including when count==TX_DEPTH; the push is accepted.
REQ-014 Pointers SHALL wrap modulo TX_DEPTH; count SHALL be log2(TX_DEPTH)+1 bits wide.
REQ-015 RX holding register:
- It SHALL load io_rx_data when it is empty and io_rx_valid=1.
- io_rx_ready SHALL equal "empty".
REQ-016 An IO read of 0x30000 SHALL return the held RX byte and empty the register if it is full, or return 8'h00 if it is empty.
REQ-017 An IO read of 0x30004 SHALL return {6'b0, tx_valid_nonfull, rx_full}, where tx_valid_nonfull = !io_buffer_full.
REQ-018 Any other IO address SHALL read 8'h00 and ignore writes.
REQ-019 If a load and a pop of the RX register happen in the same cycle, the pop SHALL take effect and the load SHALL wait until the next cycle.

Reset
REQ-020 While rst_n=0, asynchronously:
- data_read_in=0, io_buffer_full=0, io_tx_valid=0, tx_overflow=0, program_end=0.
- TX pointers and count = 0.
- RX register empty, so io_rx_ready=1.
REQ-021 RAM contents SHALL NOT be reset.
REQ-022 A reset during a pending read SHALL discard that read.
REQ-023 Reset SHALL discard any FIFO data that has not been popped.

Structure
REQ-024 IO addresses 0x30000 and 0x30004, the IO-space select value 2'b11, and the TX_DEPTH/FULL_MARGIN defaults SHALL live in a shared package/include used by this block and mem_ctrl.
REQ-025 The TX FIFO SHALL be a sub-module, byte_fifo, with push/pop/count/full/empty; RAM and decode SHALL stay in the top level.

Verification
REQ-026 Write 0xA5 to 0x00100, then read 0x00100 -> data_read_in=0xA5 exactly one cycle after the read address.
REQ-027 Six writes to 0x30000 with io_tx_ready=0 -> io_buffer_full=1 after the 6th push; pushes 7 and 8 are accepted; a 9th push is dropped and tx_overflow=1; with io_tx_ready=1 the bytes drain in order.
REQ-028 FIFO at count==8, push and pop in the same cycle -> count stays 8, order preserved, tx_overflow unchanged.
REQ-029 io_rx_data=0x41 with io_rx_valid=1, then read 0x30004 -> 0x03; read 0x30000 -> 0x41; read 0x30000 again -> 0x00.
REQ-030 rdy=0 while write 0x77 to 0x00010 is presented -> RAM is unchanged and data_read_in holds its value.
REQ-031 Assert rst_n=0 mid-drain with 3 bytes queued -> io_tx_valid=0 immediately (asynchronous) and tx_overflow=0; after release, RAM data written before reset still reads back.
